// File: rtl/gpio_in_filter.sv
// GPIO input conditioning: per-pin synchroniser, programmable debounce filter,
// edge detection and sticky edge status with a combined interrupt.
module gpio_in_filter #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DBC_WIDTH   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [WIDTH-1:0]     pad_c_i,
  input  logic [WIDTH-1:0]     dbc_en_i,
  input  logic [DBC_WIDTH-1:0] dbc_lmt_i,
  input  logic [WIDTH-1:0]     rise_en_i,
  input  logic [WIDTH-1:0]     fall_en_i,
  input  logic [WIDTH-1:0]     stat_clr_i,
  output logic [WIDTH-1:0]     filt_o,
  output logic [WIDTH-1:0]     stat_o,
  output logic                 irq_o
);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_filt;
  logic [WIDTH-1:0] r_filt_d;
  logic [WIDTH-1:0] r_stat;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;

  // Plain flop chain only: no logic between stages so metastability can settle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        r_sync[s] <= '0;
      end
    end else begin
      r_sync[0] <= pad_c_i;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  for (genvar g = 0; g < WIDTH; g++) begin : g_pin
    logic [DBC_WIDTH-1:0] r_cnt;
    logic                 r_filt;

    // Counter holds how many cycles the input has already disagreed with the
    // filtered level; reaching the limit lets the new level through.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_cnt  <= '0;
        r_filt <= 1'b0;
      end else if (!dbc_en_i[g]) begin
        r_cnt  <= '0;
        r_filt <= w_sync[g];
      end else if (w_sync[g] == r_filt) begin
        r_cnt  <= '0;
      end else if (r_cnt >= dbc_lmt_i) begin
        r_cnt  <= '0;
        r_filt <= w_sync[g];
      end else begin
        r_cnt  <= r_cnt + DBC_WIDTH'(1);
      end
    end

    assign w_filt[g] = r_filt;
  end

  assign w_rise = w_filt & ~r_filt_d;
  assign w_fall = ~w_filt & r_filt_d;

  // A new enabled edge outranks a clear arriving in the same cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_filt_d <= '0;
      r_stat   <= '0;
    end else begin
      r_filt_d <= w_filt;
      r_stat   <= (r_stat & ~stat_clr_i) | (w_rise & rise_en_i) | (w_fall & fall_en_i);
    end
  end

  assign filt_o = w_filt;
  assign stat_o = r_stat;
  assign irq_o  = |r_stat;

endmodule

// File: tb/tb_gpio_in_filter.sv
// Bench for gpio_in_filter: directed scenarios with literal expectations plus
// randomized pad waveforms compared every cycle against a behavioural model.
module tb_gpio_in_filter;
  localparam int W  = 8;
  localparam int SS = 2;
  localparam int DW = 16;

  // ---------------- clock / reset ----------------
  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic [W-1:0]  pad_c_i = '0;
  logic [W-1:0]  dbc_en_i = '0;
  logic [DW-1:0] dbc_lmt_i = '0;
  logic [W-1:0]  rise_en_i = '0;
  logic [W-1:0]  fall_en_i = '0;
  logic [W-1:0]  stat_clr_i = '0;
  logic [W-1:0]  filt_o;
  logic [W-1:0]  stat_o;
  logic          irq_o;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  always #5 clk_i = ~clk_i;

  gpio_in_filter #(.WIDTH(W), .SYNC_STAGES(SS), .DBC_WIDTH(DW)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .pad_c_i    (pad_c_i),
    .dbc_en_i   (dbc_en_i),
    .dbc_lmt_i  (dbc_lmt_i),
    .rise_en_i  (rise_en_i),
    .fall_en_i  (fall_en_i),
    .stat_clr_i (stat_clr_i),
    .filt_o     (filt_o),
    .stat_o     (stat_o),
    .irq_o      (irq_o)
  );

  // ---------------- behavioural model ----------------
  // The synchroniser is a pure delay queue of pad samples; a pin's filtered
  // level follows its input once the input has disagreed for more than L
  // consecutive edges (immediately when debounce is off).
  logic [W-1:0] pad_q[$];
  logic [W-1:0] m_filt;
  logic [W-1:0] m_filt_d;
  logic [W-1:0] m_stat;
  int unsigned  held[W];

  always @(posedge clk_i or posedge rst_i) begin
    logic [W-1:0] s;
    logic [W-1:0] moved;
    if (rst_i) begin
      pad_q.delete();
      for (int k = 0; k < SS; k++) pad_q.push_back('0);
      m_filt = '0;
      m_filt_d = '0;
      m_stat = '0;
      for (int i = 0; i < W; i++) held[i] = 0;
    end else begin
      s = pad_q.pop_front();
      pad_q.push_back(pad_c_i);
      moved = m_filt ^ m_filt_d;
      m_stat = (m_stat & ~stat_clr_i) | (moved & m_filt & rise_en_i) |
               (moved & ~m_filt & fall_en_i);
      m_filt_d = m_filt;
      for (int i = 0; i < W; i++) begin
        if (!dbc_en_i[i]) begin
          m_filt[i] = s[i];
          held[i] = 0;
        end else if (s[i] == m_filt[i]) begin
          held[i] = 0;
        end else begin
          held[i]++;
          if (held[i] > dbc_lmt_i) begin
            m_filt[i] = s[i];
            held[i] = 0;
          end
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (chk_on) begin
      check("model_filt", filt_o, m_filt);
      check("model_stat", stat_o, m_stat);
      check("model_irq", {{(W-1){1'b0}}, irq_o}, {{(W-1){1'b0}}, |m_stat});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #2;
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick(2);
    rst_i = 1'b0;
  endtask

  task automatic clear_all();
    stat_clr_i = '1;
    tick(1);
    stat_clr_i = '0;
  endtask

  task automatic edge_sel(input bit r, input bit f, input bit exp_r, input bit exp_f);
    rise_en_i = '0;
    fall_en_i = '0;
    rise_en_i[3] = r;
    fall_en_i[3] = f;
    clear_all();
    pad_c_i[3] = 1'b1;
    tick(6);
    check("edge_sel_rise", {7'b0, stat_o[3]}, {7'b0, exp_r});
    clear_all();
    pad_c_i[3] = 1'b0;
    tick(6);
    check("edge_sel_fall", {7'b0, stat_o[3]}, {7'b0, exp_f});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int hold_t[W];
    bit found;

    #1;
    rst_i = 1'b1;
    chk_on = 1'b1;

    // Reset with pads high, debounce off.
    pad_c_i = '1;
    rise_en_i = '1;
    tick(1);
    check("rst_filt", filt_o, 8'h00);
    check("rst_stat", stat_o, 8'h00);
    check("rst_irq", {7'b0, irq_o}, 8'h00);
    rst_i = 1'b0;
    tick(2);
    check("rel_filt_c2", filt_o, 8'h00);
    tick(1);
    check("rel_filt_c3", filt_o, 8'hff);
    check("rel_stat_c3", stat_o, 8'h00);
    tick(1);
    check("rel_stat_c4", stat_o, 8'hff);
    check("rel_irq_c4", {7'b0, irq_o}, 8'h01);

    // Glitch rejection at L=4.
    pad_c_i = '0;
    dbc_en_i = '1;
    dbc_lmt_i = 16'd4;
    fall_en_i = '1;
    do_reset();
    tick(3);
    pad_c_i = 8'h01;
    tick(4);
    pad_c_i = 8'h00;
    tick(12);
    check("glitch_filt", filt_o, 8'h00);
    check("glitch_stat", stat_o, 8'h00);
    pad_c_i = 8'h01;
    tick(6);
    check("hold_filt_c6", filt_o, 8'h00);
    tick(1);
    check("hold_filt_c7", filt_o, 8'h01);

    // Edge selection on pin 3, bypass.
    pad_c_i = '0;
    dbc_en_i = '0;
    do_reset();
    tick(4);
    edge_sel(1'b1, 1'b0, 1'b1, 1'b0);
    edge_sel(1'b0, 1'b1, 1'b0, 1'b1);
    edge_sel(1'b1, 1'b1, 1'b1, 1'b1);

    // Clear, then clear colliding with a new edge on pin 0.
    rise_en_i = 8'h01;
    fall_en_i = 8'h01;
    clear_all();
    pad_c_i[0] = 1'b1;
    tick(6);
    check("clr_pre", {7'b0, stat_o[0]}, 8'h01);
    stat_clr_i[0] = 1'b1;
    tick(1);
    stat_clr_i[0] = 1'b0;
    check("clr_done", {7'b0, stat_o[0]}, 8'h00);
    pad_c_i[0] = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      if (m_filt[0] != m_filt_d[0]) found = 1'b1;
      else tick(1);
    end
    check("clr_edge_wait", {7'b0, found}, 8'h01);
    stat_clr_i[0] = 1'b1;
    tick(1);
    stat_clr_i[0] = 1'b0;
    check("clr_collide_stat", {7'b0, stat_o[0]}, 8'h01);
    check("clr_collide_irq", {7'b0, irq_o}, 8'h01);

    // Limit lowered mid-count.
    pad_c_i = '0;
    dbc_en_i = '1;
    dbc_lmt_i = 16'd100;
    do_reset();
    tick(3);
    pad_c_i = 8'h01;
    tick(22);
    check("lmt_before", filt_o, 8'h00);
    dbc_lmt_i = 16'd10;
    tick(1);
    check("lmt_after", filt_o, 8'h01);

    // Randomized mixed traffic.
    for (int i = 0; i < W; i++) hold_t[i] = 0;
    for (int seg = 0; seg < 6; seg++) begin
      dbc_lmt_i = DW'($urandom_range(0, 6));
      dbc_en_i = W'($urandom);
      rise_en_i = W'($urandom);
      fall_en_i = W'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        pad_c_i = W'($urandom);
        do_reset();
      end
      for (int c = 0; c < 400; c++) begin
        for (int i = 0; i < W; i++) begin
          if (hold_t[i] == 0) begin
            pad_c_i[i] = ~pad_c_i[i];
            hold_t[i] = $urandom_range(1, 10);
          end else begin
            hold_t[i]--;
          end
        end
        stat_clr_i = ($urandom_range(0, 7) == 0) ? W'($urandom) : '0;
        if ($urandom_range(0, 99) == 0) dbc_lmt_i = DW'($urandom_range(0, 6));
        if ($urandom_range(0, 149) == 0) dbc_en_i = W'($urandom);
        tick(1);
      end
    end
    stat_clr_i = '0;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
